// File: rtl/wts_bus_master.sv
// Register-port initiator for the wave table sound core: queues write/read commands and
// replays them with fixed SETUP/STROBE/WAIT/HOLD/GAP timing. Define WTS_BUS_MASTER_FIFO_EN
// for a 4-entry command FIFO; otherwise a single skid register holds the pending command.
module wts_bus_master #(
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [14:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        busy,
  output logic        wrreq,
  output logic        rdreq,
  output logic        wr_active,
  output logic        rd_active,
  output logic [14:0] a,
  output logic [7:0]  d,
  input  logic [7:0]  q
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, HOLD, GAP} state_e;

  typedef struct packed {
    logic        write;
    logic [14:0] addr;
    logic [7:0]  wdata;
  } cmd_t;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [14:0] a_q;
  logic [7:0]  d_q;
  logic [7:0]  rdata_q;
  logic        busy_q;
  logic        run_q;
  logic        pop, push, store_empty, rsp_fire, in_window;
  cmd_t        cmd_in, head;

  assign cmd_in = {cmd_write, cmd_addr, cmd_wdata};

`ifdef WTS_BUS_MASTER_FIFO_EN
  cmd_t       fifo_q [4];
  logic [1:0] rd_ptr_q, wr_ptr_q;
  logic [2:0] count_q;

  assign store_empty = (count_q == 3'd0);
  assign head        = fifo_q[rd_ptr_q];
  assign cmd_ready   = run_q & (count_q != 3'd4);
  assign push        = cmd_valid & cmd_ready;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int unsigned i = 0; i < 4; i++) fifo_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= cmd_in;
        wr_ptr_q         <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      if (push && !pop)      count_q <= count_q + 3'd1;
      else if (!push && pop) count_q <= count_q - 3'd1;
    end
  end
`else
  cmd_t skid_q;
  logic skid_valid_q;

  assign store_empty = ~skid_valid_q;
  assign head        = skid_q;
  assign cmd_ready   = run_q & (~skid_valid_q | pop);
  assign push        = cmd_valid & cmd_ready;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      if (push) skid_q <= cmd_in;
      skid_valid_q <= push | (skid_valid_q & ~pop);
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pop      = 1'b0;
    rsp_fire = 1'b0;
    unique case (state_q)
      IDLE:   state_d = IDLE;
      SETUP:  state_d = STROBE;
      STROBE: begin
        if (write_q) begin
          state_d = HOLD;
        end else begin
          state_d = WAIT;
          cnt_d   = 3'(RD_LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          rsp_fire = 1'b1;
          state_d  = HOLD;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      HOLD: begin
        if (GAP_CYCLES == 0) begin
          state_d = IDLE;
        end else begin
          state_d = GAP;
          cnt_d   = 3'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        if (cnt_q == 3'd0) state_d = IDLE;
        else               cnt_d = cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
    // Any cycle that would land in IDLE launches the next command instead, so
    // back-to-back transactions cost no extra idle cycle.
    if (state_d == IDLE && !store_empty) begin
      pop     = 1'b1;
      state_d = SETUP;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      a_q     <= '0;
      d_q     <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
      busy_q  <= (state_q != IDLE) | ~store_empty;
      if (pop) begin
        write_q <= head.write;
        a_q     <= head.addr;
        d_q     <= head.write ? head.wdata : '0;
      end
      if (rsp_fire) rdata_q <= q;
    end
  end

  assign in_window = (state_q == SETUP) || (state_q == STROBE) ||
                     (state_q == WAIT)  || (state_q == HOLD);
  assign wr_active = in_window & write_q;
  assign rd_active = in_window & ~write_q;
  assign wrreq     = (state_q == STROBE) & write_q;
  assign rdreq     = (state_q == STROBE) & ~write_q;
  assign a         = a_q;
  assign d         = d_q;
  assign busy      = busy_q;
  // Read data is presented in the expiry cycle itself and then held.
  assign rsp_valid = rsp_fire;
  assign rsp_rdata = rsp_fire ? q : rdata_q;

endmodule

// File: tb/tb_wts_bus_master.sv
// Directed bench for wts_bus_master: three instances (default, RD_LATENCY=1/GAP=0,
// RD_LATENCY=7/GAP=0), a core model driving q, and a read-response scoreboard.
module tb_wts_bus_master;

  localparam int RLS [3] = '{2, 1, 7};
  localparam int GPS [3] = '{1, 0, 0};

  logic        clk = 1'b0;
  logic        nreset;
  logic        cmd_valid [3];
  logic        cmd_ready [3];
  logic        cmd_write;
  logic [14:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid [3];
  logic [7:0]  rsp_rdata [3];
  logic        busy [3];
  logic        wrreq [3];
  logic        rdreq [3];
  logic        wr_active [3];
  logic        rd_active [3];
  logic [14:0] a [3];
  logic [7:0]  d [3];
  logic [7:0]  q [3];

  always #5 clk = ~clk;

  wts_bus_master #(.RD_LATENCY(2), .GAP_CYCLES(1)) u_dut0 (
    .clk(clk), .nreset(nreset), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
    .wrreq(wrreq[0]), .rdreq(rdreq[0]), .wr_active(wr_active[0]), .rd_active(rd_active[0]),
    .a(a[0]), .d(d[0]), .q(q[0]));

  wts_bus_master #(.RD_LATENCY(1), .GAP_CYCLES(0)) u_dut1 (
    .clk(clk), .nreset(nreset), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
    .wrreq(wrreq[1]), .rdreq(rdreq[1]), .wr_active(wr_active[1]), .rd_active(rd_active[1]),
    .a(a[1]), .d(d[1]), .q(q[1]));

  wts_bus_master #(.RD_LATENCY(7), .GAP_CYCLES(0)) u_dut2 (
    .clk(clk), .nreset(nreset), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .busy(busy[2]),
    .wrreq(wrreq[2]), .rdreq(rdreq[2]), .wr_active(wr_active[2]), .rd_active(rd_active[2]),
    .a(a[2]), .d(d[2]), .q(q[2]));

  typedef struct {
    int         inst;
    logic [7:0] data;
  } exp_t;

  exp_t sb [$];
  int   wr_strobes [$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rsp_count = 0;
  int   rdreq_cnt0 = 0;
  int   since [3];
  int   rdreq_cyc [3];
  int   rdreq_prev [3];
  logic [14:0] rd_addr [3];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rd_model(input logic [14:0] ad);
    if (ad == 15'h0080) return 8'hC3;
    return {ad[3:0], ad[3:0]} ^ ad[11:4];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic send(input int i, input logic w, input logic [14:0] ad, input logic [7:0] wd,
                      input bit exp_rsp, output int acc);
    acc          = -1;
    cmd_valid[i] = 1'b1;
    cmd_write    = w;
    cmd_addr     = ad;
    cmd_wdata    = wd;
    if (!w && exp_rsp) sb.push_back('{i, rd_model(ad)});
    for (int n = 0; n < 100; n++) begin
      if (cmd_ready[i]) begin
        acc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (acc < 0) check("accept_timeout", acc, 0);
    @(posedge clk); #1;
    cmd_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    repeat (3) @(negedge clk);
    while (busy[i] && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy[i]) check("idle_timeout", busy[i], 0);
  endtask

  // Core model: q carries the addressed data only exactly RD_LATENCY cycles after rdreq.
  initial begin
    for (int i = 0; i < 3; i++) begin
      since[i] = -1; q[i] = '0; rd_addr[i] = '0; rdreq_cyc[i] = 0; rdreq_prev[i] = 0;
    end
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (rdreq[i]) begin
          since[i]      = 0;
          rd_addr[i]    = a[i];
          rdreq_prev[i] = rdreq_cyc[i];
          rdreq_cyc[i]  = cyc;
        end else if (since[i] >= 0) begin
          since[i]++;
        end
        if (since[i] > 8) since[i] = -1;
        q[i] = (since[i] == RLS[i]) ? rd_model(rd_addr[i]) : ~rd_model(rd_addr[i]);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rsp_valid[i]) begin
          rsp_count++;
          check("rsp_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rsp_inst", i, e.inst);
            check("rsp_data", rsp_rdata[i], e.data);
            check("rsp_latency", cyc - rdreq_cyc[i], RLS[i]);
          end
        end
        if (wr_active[i] || rd_active[i]) check("active_excl", wr_active[i] & rd_active[i], 0);
      end
      if (wrreq[0]) wr_strobes.push_back(cyc);
      if (rdreq[0]) rdreq_cnt0++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, rc0, sc0;
    int acc [5];
    int exp_acc [5];
`ifdef WTS_BUS_MASTER_FIFO_EN
    exp_acc = '{0, 1, 2, 3, 4};
`else
    exp_acc = '{0, 1, 5, 9, 13};
`endif
    nreset    = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    for (int i = 0; i < 3; i++) cmd_valid[i] = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_outs", {cmd_ready[0], rsp_valid[0], busy[0], wrreq[0], rdreq[0],
                         wr_active[0], rd_active[0], rsp_rdata[0], a[0], d[0]}, '0);
    nreset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", cmd_ready[0], 1);

    // Single write
    send(0, 1'b1, 15'h1234, 8'h5A, 1'b0, t0);
    for (int k = 1; k <= 6; k++) begin
      wait_cyc(t0 + k);
      check($sformatf("wr_ctl_t%0d", k), {wr_active[0], wrreq[0], rd_active[0], rdreq[0]},
            {(k >= 2 && k <= 4), (k == 3), 2'b00});
      if (k >= 2 && k <= 4) begin
        check("wr_addr", a[0], 15'h1234);
        check("wr_data", d[0], 8'h5A);
      end
    end
    wait_idle(0);

    // Single read
    send(0, 1'b0, 15'h0080, 8'hFF, 1'b1, t0);
    for (int k = 1; k <= 7; k++) begin
      wait_cyc(t0 + k);
      check($sformatf("rd_ctl_t%0d", k), {wr_active[0], wrreq[0], rd_active[0], rdreq[0]},
            {2'b00, (k >= 2 && k <= 6), (k == 3)});
      check($sformatf("rd_valid_t%0d", k), rsp_valid[0], (k == 5));
      if (k == 5) check("rd_rdata", rsp_rdata[0], 8'hC3);
      if (k >= 2 && k <= 6) check("rd_d_zero", d[0], 0);
    end
    wait_cyc(t0 + 9);
    check("rdata_hold", rsp_rdata[0], 8'hC3);
    wait_idle(0);

    // Back-to-back writes
    wr_strobes.delete();
    for (int k = 0; k < 5; k++) send(0, 1'b1, 15'h0100 + 15'(k), 8'h10 + 8'(k), 1'b0, acc[k]);
    t0 = acc[0];
    for (int k = 1; k < 5; k++) check($sformatf("b2b_accept%0d", k), acc[k] - t0, exp_acc[k]);
`ifdef WTS_BUS_MASTER_FIFO_EN
    wait_cyc(t0 + 5);
    check("fifo_full_stall", cmd_ready[0], 0);
    wait_cyc(t0 + 6);
    check("fifo_reopen", cmd_ready[0], 1);
`endif
    wait_cyc(t0 + 22);
    check("b2b_busy_last", busy[0], 1);
    wait_cyc(t0 + 23);
    check("b2b_busy_drop", busy[0], 0);
    check("b2b_strobe_count", wr_strobes.size(), 5);
    for (int k = 0; k < 5 && k < wr_strobes.size(); k++)
      check($sformatf("b2b_strobe%0d", k), wr_strobes[k] - t0, 3 + 4 * k);

    // Mixed ordering
    rc0 = rsp_count;
    send(0, 1'b1, 15'h0010, 8'h77, 1'b0, t0);
    send(0, 1'b0, 15'h0001, 8'h00, 1'b1, t0);
    send(0, 1'b0, 15'h0002, 8'h00, 1'b1, t0);
    wait_idle(0);
    check("mixed_rsp_count", rsp_count - rc0, 2);
    check("mixed_sb_empty", sb.size(), 0);

    // Reset during WAIT
    send(0, 1'b0, 15'h0003, 8'h00, 1'b0, t0);
    wait_cyc(t0 + 4);
    nreset = 1'b0;
    #1;
    check("reset_async_outs", {cmd_ready[0], rsp_valid[0], busy[0], wrreq[0], rdreq[0],
                               wr_active[0], rd_active[0], rsp_rdata[0], a[0], d[0]}, '0);
    rc0 = rsp_count;
    sc0 = rdreq_cnt0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    check("ready_after_abort", cmd_ready[0], 1);
    repeat (10) @(negedge clk);
    check("abort_no_rsp", rsp_count - rc0, 0);
    check("abort_no_restrobe", rdreq_cnt0 - sc0, 0);
    send(0, 1'b0, 15'h000A, 8'h00, 1'b1, t0);
    wait_idle(0);
    check("post_abort_rsp", rsp_count - rc0, 1);

    // RD_LATENCY=1, GAP_CYCLES=0
    send(1, 1'b0, 15'h0005, 8'h00, 1'b1, t0);
    send(1, 1'b0, 15'h0006, 8'h00, 1'b1, rc0);
    wait_cyc(t0 + 5);
    check("gap0_hold", rd_active[1], 1);
    wait_cyc(t0 + 6);
    check("gap0_setup", {rd_active[1], rdreq[1]}, 2'b10);
    wait_cyc(t0 + 7);
    check("gap0_strobe", rdreq[1], 1);
    wait_idle(1);
    check("rl1_spacing", rdreq_cyc[1] - rdreq_prev[1], 3 + RLS[1] + GPS[1]);

    // RD_LATENCY=7, GAP_CYCLES=0
    send(2, 1'b0, 15'h0009, 8'h00, 1'b1, t0);
    send(2, 1'b0, 15'h000C, 8'h00, 1'b1, t0);
    wait_idle(2);
    check("rl7_spacing", rdreq_cyc[2] - rdreq_prev[2], 3 + RLS[2] + GPS[2]);

    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wts_bus_master.md
Name: wts_bus_master

Overview:
- Bus initiator that drives the wave table sound core's CPU-side register port (wrreq/rdreq/wr_active/rd_active/a/d/q).
- Accepts register write/read commands over a valid/ready stream and sequences them with fixed timing onto the port.
- Returns read data over a response stream.
- Used by the host bridge and by the self-test/playback sequencer in front of the sound core.

Parameters:
- RD_LATENCY, 2, clk cycles from the rdreq strobe to q sampling; legal range 1..7.
- GAP_CYCLES, 1, idle cycles inserted between transactions with both *_active low; legal range 0..7.

Ports:
- clk  in  1  system clock
- nreset  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high
- cmd_write  in  1  1 = register write, 0 = register read
- cmd_addr  in  15  register address
- cmd_wdata  in  8  write data, ignored for reads
- rsp_valid  out  1  read data valid; one-cycle pulse
- rsp_rdata  out  8  read data
- busy  out  1  high while the command store is non-empty or the FSM is not IDLE
- wrreq  out  1  write strobe to the core
- rdreq  out  1  read strobe to the core
- wr_active  out  1  write window to the core
- rd_active  out  1  read window to the core
- a  out  15  address to the core
- d  out  8  write data to the core
- q  in  8  read data from the core

Behaviour:
- Reset: a single clock domain (clk) with an asynchronous active-low reset (nreset), as already decided.
  - While nreset is low, every output is 0, the FSM is IDLE and the command store is empty.
  - Reset mid-transaction aborts the transaction and drops any pending response; no strobe is reissued after reset.
- Command store:
  - Holds one entry (skid register) by default.
  - cmd_ready = store not full.
  - An accept and a pop in the same cycle are allowed, giving 1 command/transaction of throughput.
- FSM states and transitions:
  - IDLE: if the store is non-empty, pop the head, latch a/d (d = 0 for reads) and go to SETUP.
  - SETUP (1 cycle): assert wr_active or rd_active to match the command type; a/d are stable.
  - STROBE (1 cycle): active stays high; pulse wrreq or rdreq high for exactly 1 cycle. A write then goes to HOLD; a read goes to WAIT.
  - WAIT: a 3-bit counter counts RD_LATENCY cycles after STROBE. On the cycle the counter expires, capture q into rsp_rdata, pulse rsp_valid for 1 cycle, then go to HOLD.
  - HOLD (1 cycle): active stays high; strobes are low.
  - GAP: both *_active low for GAP_CYCLES cycles, then go to IDLE. If GAP_CYCLES = 0, go directly to IDLE.
- Invariants:
  - a and d are stable from SETUP through HOLD.
  - wr_active and rd_active are never high together.
  - wrreq and rdreq are never high outside their STROBE cycle.
- Timing:
  - Write cost = 3 + GAP_CYCLES cycles.
  - Read cost = 3 + RD_LATENCY + GAP_CYCLES cycles.
  - rsp_valid is asserted RD_LATENCY cycles after rdreq.
- Response ordering: responses are issued in command order; writes produce no response.
- rsp_rdata holds its value until the next read captures.
- No backpressure on rsp_*; the consumer must accept every pulse.
- busy is registered and updates one cycle after the state change.

Optional Feature:
- Macro: WTS_BUS_MASTER_FIFO_EN.
- Defined:
  - The command store is a 4-entry circular FIFO with 2-bit read/write pointers and a 3-bit count.
  - cmd_ready = (count != 4).
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap 3 -> 0.
- Undefined: a single-entry skid register; cmd_ready = store empty, or store being popped in this cycle.

Test Plan:
- Write: cmd write a=0x1234, d=0x5A at T0 -> wr_active high from T0+2 to T0+4, wrreq high at T0+3 only, a=0x1234 and d=0x5A over T0+2..T0+4, both *_active low at T0+5 (GAP_CYCLES=1).
- Read: cmd read a=0x0080, q driven 0xC3 at rdreq+2 -> rsp_valid pulses 1 cycle at rdreq+2 with rsp_rdata=0xC3, no wrreq activity, d=0.
- Back-to-back (FIFO_EN): 4 writes offered on consecutive cycles -> all 4 accepted, 5th command stalls (cmd_ready=0) until the first pop; strobes spaced exactly 4 cycles apart; busy drops 1 cycle after the last GAP.
- Mixed ordering: write, read(0x0001 -> 0x11), read(0x0002 -> 0x22) -> exactly 2 rsp_valid pulses in order 0x11 then 0x22.
- Reset mid-read: nreset low during WAIT -> all outputs 0 asynchronously; after release no rsp_valid is issued, cmd_ready=1 and the next command executes normally.
- Parameter sweep: RD_LATENCY=1 and 7, GAP_CYCLES=0 -> captured q matches the value driven exactly RD_LATENCY cycles after rdreq; with GAP_CYCLES=0 the next SETUP follows HOLD directly.
